// File: rtl/clk_div_n.sv
// clk_div_n: programmable divide-by-N tick/clock generator; CLKDIV_SYNC_EN adds the sync phase-realign input.
module clk_div_n #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [CNT_W-1:0] count,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err,
  output logic             div_pend
);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
  logic [CNT_W-1:0] count_q, count_d, div_act_q, div_act_d, div_nxt_q, div_nxt_d;
  logic clk_out_q, clk_out_d, tick_q, tick_d, div_err_q, div_err_d, div_pend_q, div_pend_d;
  logic valid, ld_ok, wrap;
  assign valid = div_val >= CNT_W'(2);
  assign ld_ok = div_load && valid;
  assign wrap  = enable && (count_q == div_act_q - 1'b1);
  always_comb begin
    count_d    = count_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    div_act_d  = div_act_q;
    div_nxt_d  = div_nxt_q;
    div_pend_d = div_pend_q;
    div_err_d  = div_err_q | (div_load && !valid);
`ifdef CLKDIV_SYNC_EN
    if (sync) begin
      count_d    = '0;
      clk_out_d  = 1'b0;
      div_err_d  = div_err_q;
      div_act_d  = div_pend_q ? div_nxt_q : div_act_q;
      div_pend_d = 1'b0;
    end else
`endif
    if (wrap) begin
      count_d    = '0;
      clk_out_d  = ~clk_out_q;
      tick_d     = 1'b1;
      // a load landing on the wrap edge bypasses the pending stage
      div_act_d  = ld_ok ? div_val : div_pend_q ? div_nxt_q : div_act_q;
      div_nxt_d  = ld_ok ? div_val : div_nxt_q;
      div_pend_d = 1'b0;
    end else begin
      count_d    = enable ? count_q + 1'b1 : count_q;
      div_nxt_d  = ld_ok ? div_val : div_nxt_q;
      div_pend_d = div_pend_q | ld_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
      div_pend_q <= 1'b0;
      div_act_q  <= DIV_RST;
      div_nxt_q  <= DIV_RST;
    end else begin
      count_q    <= count_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      div_err_q  <= div_err_d;
      div_pend_q <= div_pend_d;
      div_act_q  <= div_act_d;
      div_nxt_q  <= div_nxt_d;
    end
  end
  assign count    = count_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign div_err  = div_err_q;
  assign div_pend = div_pend_q;
endmodule
